// File: rtl/matdet_pkg.sv
// Shared types and helpers for the matdet scheduler: FSM state encoding,
// requester-ID width and the largest supported matrix size.
package matdet_pkg;

  localparam int MATDET_MAX_SIZE = 4;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SETTLE,
    OUT
  } matdet_state_t;

  function automatic int id_width(input int n_req);
    return (n_req > 1) ? $clog2(n_req) : 1;
  endfunction

endpackage

// File: rtl/matdet_dets.sv
// Combinational fixed-point determinant datapaths for 2x2, 3x3 and 4x4
// matrices; operand element k (row-major) sits at [k*DATA_WIDTH +: DATA_WIDTH].
module matdet2 #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic [4*DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0]   det
);

  function automatic logic signed [DATA_WIDTH-1:0] fmul(input logic signed [DATA_WIDTH-1:0] a,
                                                       input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return DATA_WIDTH'(p >>> BIN_POS);
  endfunction

  assign det = fmul(operand[0 +: DATA_WIDTH], operand[3*DATA_WIDTH +: DATA_WIDTH])
             - fmul(operand[DATA_WIDTH +: DATA_WIDTH], operand[2*DATA_WIDTH +: DATA_WIDTH]);

endmodule

module matdet3 #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic [9*DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0]   det
);

  function automatic logic signed [DATA_WIDTH-1:0] fmul(input logic signed [DATA_WIDTH-1:0] a,
                                                       input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return DATA_WIDTH'(p >>> BIN_POS);
  endfunction

  logic [DATA_WIDTH-1:0] e [9];
  logic [DATA_WIDTH-1:0] m0, m1, m2;

  always_comb for (int k = 0; k < 9; k++) e[k] = operand[k*DATA_WIDTH +: DATA_WIDTH];

  // First-row cofactor expansion; each minor is a 2x2 over rows 1..2.
  matdet2 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_m0 (.operand({e[8], e[7], e[5], e[4]}), .det(m0));
  matdet2 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_m1 (.operand({e[8], e[6], e[5], e[3]}), .det(m1));
  matdet2 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_m2 (.operand({e[7], e[6], e[4], e[3]}), .det(m2));

  assign det = fmul(e[0], m0) - fmul(e[1], m1) + fmul(e[2], m2);

endmodule

module matdet4 #(
  parameter int DATA_WIDTH = 32,
  parameter int BIN_POS    = 16
) (
  input  logic [16*DATA_WIDTH-1:0] operand,
  output logic [DATA_WIDTH-1:0]    det
);

  function automatic logic signed [DATA_WIDTH-1:0] fmul(input logic signed [DATA_WIDTH-1:0] a,
                                                       input logic signed [DATA_WIDTH-1:0] b);
    logic signed [2*DATA_WIDTH-1:0] p;
    p = (2*DATA_WIDTH)'(a) * (2*DATA_WIDTH)'(b);
    return DATA_WIDTH'(p >>> BIN_POS);
  endfunction

  logic [DATA_WIDTH-1:0] md [4];

  for (genvar j = 0; j < 4; j++) begin : g_minor
    logic [9*DATA_WIDTH-1:0] sub;
    always_comb begin
      sub = '0;
      for (int r = 1; r < 4; r++)
        for (int c = 0; c < 4; c++)
          if (c != j)
            sub[((r-1)*3 + ((c < j) ? c : c-1))*DATA_WIDTH +: DATA_WIDTH] = operand[(r*4+c)*DATA_WIDTH +: DATA_WIDTH];
    end
    matdet3 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_minor (.operand(sub), .det(md[j]));
  end

  assign det = fmul(operand[0 +: DATA_WIDTH], md[0])
             - fmul(operand[DATA_WIDTH +: DATA_WIDTH], md[1])
             + fmul(operand[2*DATA_WIDTH +: DATA_WIDTH], md[2])
             - fmul(operand[3*DATA_WIDTH +: DATA_WIDTH], md[3]);

endmodule

// File: rtl/matdet_rr_arb.sv
// Round-robin arbiter: picks the first requester at or after last_grant+1,
// wrapping around, and flags whether any request is present.
module matdet_rr_arb #(
  parameter int N_REQ = 2,
  parameter int ID_W  = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  last_grant,
  output logic [ID_W-1:0]  grant,
  output logic             any_req
);

  always_comb begin
    int idx;
    idx     = 0;
    grant   = '0;
    any_req = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!any_req && |(req & (N_REQ'(1) << idx))) begin
        any_req = 1'b1;
        grant   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/matdet_sched.sv
// Job sequencer sharing one matdetN among N_REQ element-serial requesters.
// Optional out_singular flag is enabled with `define MATDET_SCHED_SINGULAR_EN.
module matdet_sched
  import matdet_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int BIN_POS       = 16,
  parameter int MATRIX_SIZE   = 3,
  parameter int N_REQ         = 2,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_REQ-1:0]              in_valid,
  input  logic [N_REQ*DATA_WIDTH-1:0]   in_data,
  output logic [N_REQ-1:0]              in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_WIDTH-1:0]         out_det,
  output logic [id_width(N_REQ)-1:0]    out_id,
`ifdef MATDET_SCHED_SINGULAR_EN
  output logic                          out_singular,
`endif
  output logic                          busy
);

  localparam int ID_W   = id_width(N_REQ);
  localparam int NN     = MATRIX_SIZE * MATRIX_SIZE;
  localparam int BEAT_W = $clog2(NN);
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  matdet_state_t            state_q, state_d;
  logic [ID_W-1:0]          grant_q, grant_d;
  logic [ID_W-1:0]          last_grant_q, last_grant_d;
  logic [BEAT_W-1:0]        beat_cnt_q, beat_cnt_d;
  logic [SET_W-1:0]         settle_cnt_q, settle_cnt_d;
  logic [NN*DATA_WIDTH-1:0] operand_q, operand_d;
  logic [DATA_WIDTH-1:0]    out_det_q, out_det_d;
  logic [ID_W-1:0]          out_id_q, out_id_d;
`ifdef MATDET_SCHED_SINGULAR_EN
  logic                     singular_q, singular_d;
`endif

  logic [ID_W-1:0]          arb_grant;
  logic                     any_req;
  logic                     sel_valid;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [DATA_WIDTH-1:0]    det_w;

  matdet_rr_arb #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
    .req        (in_valid),
    .last_grant (last_grant_q),
    .grant      (arb_grant),
    .any_req    (any_req)
  );

  if (MATRIX_SIZE == 2) begin : g_det2
    matdet2 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_det (.operand(operand_q), .det(det_w));
  end else if (MATRIX_SIZE == 3) begin : g_det3
    matdet3 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_det (.operand(operand_q), .det(det_w));
  end else if (MATRIX_SIZE == MATDET_MAX_SIZE) begin : g_det4
    matdet4 #(.DATA_WIDTH(DATA_WIDTH), .BIN_POS(BIN_POS)) u_det (.operand(operand_q), .det(det_w));
  end else begin : g_det_none
    assign det_w = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= ID_W'(N_REQ - 1);
      beat_cnt_q   <= '0;
      settle_cnt_q <= '0;
      operand_q    <= '0;
      out_det_q    <= '0;
      out_id_q     <= '0;
`ifdef MATDET_SCHED_SINGULAR_EN
      singular_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_cnt_q   <= beat_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      operand_q    <= operand_d;
      out_det_q    <= out_det_d;
      out_id_q     <= out_id_d;
`ifdef MATDET_SCHED_SINGULAR_EN
      singular_q   <= singular_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_cnt_d   = beat_cnt_q;
    settle_cnt_d = settle_cnt_q;
    operand_d    = operand_q;
    out_det_d    = out_det_q;
    out_id_d     = out_id_q;
`ifdef MATDET_SCHED_SINGULAR_EN
    singular_d   = singular_q;
`endif
    in_ready     = '0;
    out_valid    = 1'b0;
    sel_valid    = 1'b0;
    sel_data     = '0;

    for (int r = 0; r < N_REQ; r++) begin
      if (grant_q == ID_W'(r)) begin
        sel_valid = in_valid[r];
        sel_data  = in_data[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = arb_grant;
          state_d = LOAD;
        end
      end
      LOAD: begin
        for (int r = 0; r < N_REQ; r++)
          if (grant_q == ID_W'(r)) in_ready[r] = 1'b1;
        if (sel_valid) begin
          for (int k = 0; k < NN; k++)
            if (beat_cnt_q == BEAT_W'(k)) operand_d[k*DATA_WIDTH +: DATA_WIDTH] = sel_data;
          if (beat_cnt_q == BEAT_W'(NN - 1)) begin
            beat_cnt_d = '0;
            state_d    = SETTLE;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      // Operand is frozen here so the combinational determinant can settle.
      SETTLE: begin
        if (settle_cnt_q == SET_W'(SETTLE_CYCLES - 1)) begin
          settle_cnt_d = '0;
          out_det_d    = det_w;
          out_id_d     = grant_q;
`ifdef MATDET_SCHED_SINGULAR_EN
          singular_d   = (det_w == '0);
`endif
          state_d      = OUT;
        end else begin
          settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
      end
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q != IDLE);
  assign out_det = out_det_q;
  assign out_id  = out_id_q;
`ifdef MATDET_SCHED_SINGULAR_EN
  assign out_singular = singular_q;
`endif

endmodule

// File: tb/tb_matdet_sched.sv
// Scoreboard bench for matdet_sched (2x2, Q16.16, two requesters).
module tb_matdet_sched;

  localparam int DW = 32;
  localparam int SC = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    in_valid;
  logic [2*DW-1:0] in_data;
  logic [1:0]    in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_det;
  logic [0:0]    out_id;
  logic          busy;
`ifdef MATDET_SCHED_SINGULAR_EN
  logic          out_singular;
`endif

  logic          tb_valid [2];
  logic [DW-1:0] tb_data  [2];

  typedef struct {
    logic [DW-1:0] det;
    logic [0:0]    id;
    logic          sing;
  } exp_t;

  exp_t exp_q [$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   onehot_viol = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_valid[i]           = tb_valid[i];
      in_data[i*DW +: DW]   = tb_data[i];
    end
  end

  matdet_sched #(
    .DATA_WIDTH(32), .BIN_POS(16), .MATRIX_SIZE(2), .N_REQ(2), .SETTLE_CYCLES(SC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_det   (out_det),
    .out_id    (out_id),
`ifdef MATDET_SCHED_SINGULAR_EN
    .out_singular (out_singular),
`endif
    .busy      (busy)
  );

  function automatic logic [DW-1:0] q(input int v);
    return DW'(v <<< 16);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic push(input logic [DW-1:0] det, input logic [0:0] id, input logic sing);
    exp_t e;
    e.det = det; e.id = id; e.sing = sing;
    exp_q.push_back(e);
  endtask

  // Monitor: every handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && (in_ready[0] && in_ready[1])) onehot_viol++;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_result", out_det, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result_det", out_det, e.det);
        chk("result_id", 32'(out_id), 32'(e.id));
`ifdef MATDET_SCHED_SINGULAR_EN
        chk("result_singular", 32'(out_singular), 32'(e.sing));
`endif
      end
    end
  end

  task automatic send_job(input int r, input logic [DW-1:0] a, b, c, d,
                          input int n_beats, input int stall_after, input int stall_len,
                          output int last_cyc);
    logic [DW-1:0] el [4];
    el[0] = a; el[1] = b; el[2] = c; el[3] = d;
    last_cyc = -1;
    for (int k = 0; k < n_beats; k++) begin
      int guard;
      guard = 0;
      tb_valid[r] = 1'b1;
      tb_data[r]  = el[k];
      @(negedge clk);
      while (!in_ready[r] && guard < 500) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 500) begin
        chk("beat_accept_timeout", 32'(k), 32'hFFFF_FFFF);
        tb_valid[r] = 1'b0;
        return;
      end
      @(posedge clk); #1;
      last_cyc = cyc;
      if (k == stall_after) begin
        tb_valid[r] = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
    end
    tb_valid[r] = 1'b0;
  endtask

  task automatic wait_out(output int vc);
    int guard;
    guard = 0;
    vc = -1;
    @(negedge clk);
    while (!out_valid && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) chk("out_valid_timeout", 32'(guard), 32'd0);
    else vc = cyc;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, vc, st;
    rst_n = 1'b0;
    out_ready = 1'b1;
    tb_valid[0] = 1'b0; tb_valid[1] = 1'b0;
    tb_data[0] = '0;    tb_data[1] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_det", out_det, 32'd0);
    chk("reset_out_id", 32'(out_id), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // Single job, latency and total job length
    push(32'h000A_0000, 1'b0, 1'b0);
    st = cyc;
    send_job(0, q(3), q(1), q(2), q(4), 4, -1, 0, acc);
    wait_out(vc);
    chk("single_last_beat_to_valid", 32'(vc - acc), 32'(SC));
    chk("single_job_len", 32'(vc - st), 32'(1 + 4 + SC));
    chk("busy_in_out", 32'(busy), 32'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Input stall of 3 cycles after beat 1
    push(32'h000A_0000, 1'b0, 1'b0);
    st = cyc;
    send_job(0, q(3), q(1), q(2), q(4), 4, 1, 3, acc);
    wait_out(vc);
    chk("stall_job_len", 32'(vc - st), 32'(1 + 4 + SC + 3));
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Backpressure: out_ready low for 5 cycles, requester 1 waiting
    push(32'h000A_0000, 1'b0, 1'b0);
    out_ready = 1'b0;
    send_job(0, q(3), q(1), q(2), q(4), 4, -1, 0, acc);
    wait_out(vc);
    tb_valid[1] = 1'b1;
    tb_data[1]  = q(5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out_det", out_det, 32'h000A_0000);
      chk("bp_out_id", 32'(out_id), 32'd0);
      chk("bp_no_grant", 32'(in_ready), 32'd0);
    end
    push(32'h000D_0000, 1'b1, 1'b0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send_job(1, q(5), q(2), q(1), q(3), 4, -1, 0, acc);
    wait_out(vc);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Mid-job reset after beat 2, then requester 1 alone
    send_job(0, q(3), q(1), q(2), q(4), 3, -1, 0, acc);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_det", out_det, 32'd0);
    chk("midrst_out_id", 32'(out_id), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    push(32'hFFFE_0000, 1'b1, 1'b0);
    send_job(1, q(1), q(2), q(3), q(4), 4, -1, 0, acc);
    wait_out(vc);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Contention from reset: expected service order 0,1,0,1
    rst_n = 1'b0;
    push(32'h000A_0000, 1'b0, 1'b0);
    push(32'h000D_0000, 1'b1, 1'b0);
    push(32'hFFFE_0000, 1'b0, 1'b0);
    push(32'h0002_0000, 1'b1, 1'b0);
    fork
      begin
        int a0;
        send_job(0, q(3), q(1), q(2), q(4), 4, -1, 0, a0);
        send_job(0, q(1), q(2), q(3), q(4), 4, -1, 0, a0);
      end
      begin
        int a1;
        send_job(1, q(5), q(2), q(1), q(3), 4, -1, 0, a1);
        send_job(1, 32'h0000_8000, q(1), q(1), q(6), 4, -1, 0, a1);
      end
      begin
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
    join
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    @(posedge clk); #1;

`ifdef MATDET_SCHED_SINGULAR_EN
    push(32'h0000_0000, 1'b0, 1'b1);
    send_job(0, q(1), q(2), q(2), q(4), 4, -1, 0, acc);
    wait_out(vc);
    @(posedge clk); #1;
    push(32'h000A_0000, 1'b0, 1'b0);
    send_job(0, q(3), q(1), q(2), q(4), 4, -1, 0, acc);
    wait_out(vc);
    @(posedge clk); #1;
`endif

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("in_ready_onehot", 32'(onehot_viol), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
